sram_ctrl: RTL and testbench

Synchronous bus controller for the devboard's external 128K x 8 asynchronous SRAM. Accepts 32-bit word read/write requests over a valid/ready handshake and converts each one into a sequence of byte-wide SRAM cycles. It generates chip-enable, write-enable and output-enable strobes with a programmable number of wait cycles per byte. It sits between the hs32 memory bus and the SRAM pins; the DQ tristate buffer lives in the top level.

---
 rtl/sram_ctrl_if.sv | 24 ++
 rtl/sram_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Request/response bus between the hs32 memory bus master and sram_ctrl.
// The master drives requests; the controller (slave) answers with ready and response.
interface sram_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-3:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// Word-to-byte controller for a 128K x 8 asynchronous SRAM. Each 32-bit request
// becomes a sequence of byte cycles with WAIT_CYCLES-long CE/WE/OE strobes.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rstn,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_a,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_ce2,
  output logic              sram_we_n,
  output logic              sram_oe_n
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_STROBE, WR_HOLD, DONE} state_t;

  state_t            state, state_d;
  logic [1:0]        k, k_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       rdata_q;
  logic              accept;
  logic              rd_latch;
  logic [2:0]        first_sel;
  logic [2:0]        next_sel;

  // Returns {found, index} of the lowest enabled byte at or above 'from'.
  function automatic logic [2:0] pick_byte(input logic [3:0] be, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (be[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign first_sel = pick_byte(bus.req_be, 3'd0);
  assign next_sel  = pick_byte(be_q, {1'b0, k} + 3'd1);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state;
    k_d          = k;
    cnt_d        = cnt;
    accept       = 1'b0;
    rd_latch     = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    sram_ce_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_dq_oe   = 1'b0;

    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (!bus.req_we) begin
            state_d = RD;
            k_d     = 2'd0;
          end else if (first_sel[2]) begin
            state_d = WR_SETUP;
            k_d     = first_sel[1:0];
          end else begin
            state_d = DONE;
          end
        end
      end
      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if (cnt == CNT_LAST) begin
          rd_latch = 1'b1;
          cnt_d    = '0;
          if (k == 2'd3) state_d = DONE;
          else           k_d     = k + 2'd1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WR_SETUP: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        state_d    = WR_STROBE;
        cnt_d      = '0;
      end
      WR_STROBE: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_we_n  = 1'b0;
        if (cnt == CNT_LAST) state_d = WR_HOLD;
        else                 cnt_d   = cnt + 1'b1;
      end
      WR_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        // Disabled bytes are skipped entirely, costing no cycles.
        if (next_sel[2]) begin
          state_d = WR_SETUP;
          k_d     = next_sel[1:0];
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      k     <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      k     <= k_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
      if (rd_latch) rdata_q[8*k +: 8] <= sram_dq_i;
    end
  end

  // Address and data come straight from registers, so they only move on byte changes.
  assign sram_a         = {addr_q, k};
  assign sram_dq_o      = wdata_q[8*k +: 8];
  assign sram_ce2       = ~sram_ce_n;
  assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized scoreboard bench for sram_ctrl with a behavioural SRAM and a byte-array
// reference model; also checks strobe shape, turnaround and reset abort.
module tb_sram_ctrl;
  localparam int W  = 3;
  localparam int AW = 17;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(AW)) bus ();

  logic [AW-1:0] sram_a;
  logic [7:0]    sram_dq_o;
  logic [7:0]    sram_dq_i;
  logic          sram_dq_oe, sram_ce_n, sram_ce2, sram_we_n, sram_oe_n;

  sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .sram_a     (sram_a),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_ce2   (sram_ce2),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  // Behavioural SRAM and the independent reference image.
  logic [7:0] mem     [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];
  assign sram_dq_i = mem[sram_a];
  always @(posedge clk) if (rstn && !sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_a] <= sram_dq_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_rd; logic [31:0] data; int due; } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops plus strobe-shape observations.
  int            we_pulses = 0;
  int            ce_low    = 0;
  int            we_len    = 0;
  logic          prev_we_n = 1'b1, prev_dq_oe = 1'b0, prev_oe_n = 1'b1, prev_ce_n = 1'b1;
  logic [AW-1:0] prev_a    = '0;
  logic [AW-1:0] strobe_a  = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_we_n  = 1'b1;
      prev_dq_oe = 1'b0;
      prev_oe_n  = 1'b1;
      prev_ce_n  = 1'b1;
      we_len     = 0;
    end else begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_cycle", 32'(cyc), 32'(e.due));
          if (e.is_rd) check("rdata", bus.resp_rdata, e.data);
        end
      end
      if (sram_ce_n != prev_ce_n) check("ce2", 32'(sram_ce2), 32'(!sram_ce_n));
      if (!sram_ce_n) ce_low++;
      if (prev_we_n && !sram_we_n) begin
        we_pulses++;
        we_len   = 1;
        strobe_a = sram_a;
        check("a_setup", 32'(sram_a), 32'(prev_a));
      end else if (!sram_we_n) begin
        we_len++;
        check("a_strobe", 32'(sram_a), 32'(strobe_a));
      end else if (!prev_we_n) begin
        check("we_width", 32'(we_len), 32'(W));
        check("a_hold", 32'(sram_a), 32'(strobe_a));
        check("hold_dq_oe", 32'(sram_dq_oe), 32'd1);
      end
      if (sram_dq_oe && !prev_dq_oe) check("turnaround", 32'(prev_oe_n), 32'd1);
      if (sram_dq_oe) check("oe_n_in_write", 32'(sram_oe_n), 32'd1);
      prev_we_n  = sram_we_n;
      prev_dq_oe = sram_dq_oe;
      prev_oe_n  = sram_oe_n;
      prev_ce_n  = sram_ce_n;
    end
    prev_a = sram_a;
  end

  // Issue one request; the reference model computes data and latency from the rules.
  task automatic issue(input logic we, input logic [AW-3:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    int   n;
    int   nbytes;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    e.is_rd = !we;
    e.data  = '0;
    if (we) begin
      nbytes = 0;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          ref_mem[{addr, 2'(b)}] = wdata[8*b +: 8];
          nbytes++;
        end
      end
      e.due = cyc + 1 + nbytes * (W + 2);
    end else begin
      for (int b = 0; b < 4; b++) e.data[8*b +: 8] = ref_mem[{addr, 2'(b)}];
      e.due = cyc + 1 + 4 * W;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = 15'($urandom);
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int p0, c0, n;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_dq_o", 32'(sram_dq_o), 32'd0);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_ce2", 32'(sram_ce2), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    #20 rstn = 1'b1;
    #1 check("rst_ready", 32'(bus.req_ready), 32'd1);

    // Full write then read back.
    issue(1'b1, 15'h0010, 32'hA5C3F00F, 4'hF);
    wait_idle();
    check("mem_0x40", 32'(mem[17'h40]), 32'h0F);
    check("mem_0x41", 32'(mem[17'h41]), 32'hF0);
    check("mem_0x42", 32'(mem[17'h42]), 32'hC3);
    check("mem_0x43", 32'(mem[17'h43]), 32'hA5);
    issue(1'b0, 15'h0010, 32'h0, 4'h0);
    wait_idle();

    // Partial write: only two strobes, bytes 1 and 3 untouched.
    issue(1'b1, 15'h0020, 32'h11223344, 4'hF);
    wait_idle();
    p0 = we_pulses;
    issue(1'b1, 15'h0020, 32'hAABBCCDD, 4'b0101);
    wait_idle();
    check("partial_we_pulses", 32'(we_pulses - p0), 32'd2);
    check("partial_mem", {mem[17'h83], mem[17'h82], mem[17'h81], mem[17'h80]}, 32'h11BB33DD);
    issue(1'b0, 15'h0020, 32'h0, 4'h0);
    wait_idle();

    // Write with no enabled bytes never touches the SRAM.
    p0 = we_pulses;
    c0 = ce_low;
    issue(1'b1, 15'h0030, 32'hFFFFFFFF, 4'h0);
    wait_idle();
    check("be0_we_pulses", 32'(we_pulses - p0), 32'd0);
    check("be0_ce_low", 32'(ce_low - c0), 32'd0);

    // Reset during the second write strobe aborts without a response.
    p0 = we_pulses;
    issue(1'b1, 15'h0040, 32'h01020304, 4'hF);
    n = 0;
    while (we_pulses < p0 + 2 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reach_second_strobe", 32'(we_pulses - p0), 32'd2);
    rstn = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_ce_n", 32'(sram_ce_n), 32'd1);
    check("abort_oe_n", 32'(sram_oe_n), 32'd1);
    check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 check("abort_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b1, 15'h0040, 32'hCAFEF00D, 4'hF);
    issue(1'b0, 15'h0040, 32'h0, 4'h0);
    wait_idle();

    // Random traffic over a small window so reads hit earlier writes.
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)), 15'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)));
    end
    wait_idle();
    for (int i = 0; i < 16; i++) issue(1'b0, 15'(i), 32'h0, 4'h0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
